// File: rtl/div_controller.sv
// Sequencing FSM for an N-iteration shift/subtract divider: load, initial shift, N iterate strobes, final right shift.
// Every output is a registered decode of the current state, so each strobe appears one clock after its state is entered.
module div_controller #(
    parameter int N = 32
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic                Divisor_zero,
    output logic                W_ctrl,
    output logic                SLL_ctrl,
    output logic                SRL_ctrl,
    output logic                Ready,
    output logic                Busy,
    output logic                Div_zero,
    output logic [$clog2(N):0]  Count
);
    localparam int            CW   = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT0,
        ITER,
        FIX,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] iter_q, iter_d;
    logic          abort_q, abort_d;

    logic          w_ctrl_q, w_ctrl_d;
    logic          sll_ctrl_q, sll_ctrl_d;
    logic          srl_ctrl_q, srl_ctrl_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          div_zero_q, div_zero_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        abort_d = abort_q;
        case (state_q)
            IDLE: begin
                if (Start) state_d = LOAD;
            end
            LOAD: begin
                iter_d  = '0;
                abort_d = Divisor_zero;
                state_d = Divisor_zero ? DONE : SHIFT0;
            end
            SHIFT0: begin
                state_d = ITER;
            end
            // The index holds at its last value on exit so Count never wraps while iterating.
            ITER: begin
                if (iter_q == LAST) state_d = FIX;
                else                iter_d  = iter_q + CW'(1);
            end
            FIX: begin
                state_d = DONE;
            end
            DONE: begin
                if (Start) state_d = LOAD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        w_ctrl_d   = (state_q == LOAD);
        sll_ctrl_d = (state_q == SHIFT0) || (state_q == ITER);
        srl_ctrl_d = (state_q == FIX);
        ready_d    = (state_q == DONE);
        busy_d     = (state_q == LOAD) || (state_q == SHIFT0) ||
                     (state_q == ITER) || (state_q == FIX);
        div_zero_d = (state_q == DONE) && abort_q;
        count_d    = (state_q == ITER) ? iter_q : '0;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            iter_q     <= '0;
            abort_q    <= 1'b0;
            w_ctrl_q   <= 1'b0;
            sll_ctrl_q <= 1'b0;
            srl_ctrl_q <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            div_zero_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            iter_q     <= iter_d;
            abort_q    <= abort_d;
            w_ctrl_q   <= w_ctrl_d;
            sll_ctrl_q <= sll_ctrl_d;
            srl_ctrl_q <= srl_ctrl_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            div_zero_q <= div_zero_d;
            count_q    <= count_d;
        end
    end

    assign W_ctrl   = w_ctrl_q;
    assign SLL_ctrl = sll_ctrl_q;
    assign SRL_ctrl = srl_ctrl_q;
    assign Ready    = ready_q;
    assign Busy     = busy_q;
    assign Div_zero = div_zero_q;
    assign Count    = count_q;

endmodule

// File: tb/tb_div_controller.sv
// Bench for div_controller: a timeline model (edges since Start) predicts every output each cycle,
// and a behavioural shift/subtract datapath driven by the strobes checks real quotients.
module tb_div_controller;
    localparam int N  = 32;
    localparam int CW = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          Reset, Start, Divisor_zero;
    logic          W_ctrl, SLL_ctrl, SRL_ctrl, Ready, Busy, Div_zero;
    logic [CW-1:0] Count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int w_seen   = 0;

    // Timeline model: m_t counts edges since Start was accepted.
    bit m_active = 0;
    bit m_abort  = 0;
    int m_t      = 0;
    bit e_w, e_sll, e_srl, e_ready, e_busy, e_dz;
    int e_cnt;

    logic [31:0] op_a = 32'd0, op_b = 32'd1;
    logic [32:0] dp_hi;
    logic [31:0] dp_lo, dp_dvs;
    logic        dp_first;

    always #5 clk = ~clk;

    div_controller #(.N(N)) dut (
        .clk          (clk),
        .Reset        (Reset),
        .Start        (Start),
        .Divisor_zero (Divisor_zero),
        .W_ctrl       (W_ctrl),
        .SLL_ctrl     (SLL_ctrl),
        .SRL_ctrl     (SRL_ctrl),
        .Ready        (Ready),
        .Busy         (Busy),
        .Div_zero     (Div_zero),
        .Count        (Count)
    );

    // Restoring divider with a 33-bit upper half so large divisors cannot overflow the shift.
    always @(posedge clk) begin
        if (W_ctrl === 1'b1) begin
            dp_hi    <= '0;
            dp_lo    <= op_a;
            dp_dvs   <= op_b;
            dp_first <= 1'b1;
        end else if (SLL_ctrl === 1'b1) begin
            dp_first <= 1'b0;
            if (!dp_first && dp_hi >= {1'b0, dp_dvs})
                {dp_hi, dp_lo} <= ({dp_hi - {1'b0, dp_dvs}, dp_lo} << 1) | 65'd1;
            else
                {dp_hi, dp_lo} <= {dp_hi, dp_lo} << 1;
        end else if (SRL_ctrl === 1'b1) begin
            dp_hi <= dp_hi >> 1;
        end
    end

    function automatic bit m_final();
        return m_abort ? (m_t >= 2) : (m_t >= N + 4);
    endfunction

    function automatic bit start_ignored();
        return m_active && (m_t == 0 || (!m_abort && m_t <= N + 2));
    endfunction

    function automatic logic pick_dz();
        if (m_active && m_t == 0) return (op_b == 32'd0);
        return 1'($urandom);
    endfunction

    task automatic set_idle();
        e_w = 0; e_sll = 0; e_srl = 0; e_ready = 0; e_busy = 0; e_dz = 0; e_cnt = 0;
    endtask

    task automatic model_edge(input logic rst, input logic st, input logic dz);
        if (rst) begin
            m_active = 0; m_t = 0; m_abort = 0;
            set_idle();
        end else if (!m_active) begin
            set_idle();
            if (st) begin m_active = 1; m_t = 0; m_abort = 0; end
        end else begin
            if (!m_final()) m_t++;
            if (m_t == 1) m_abort = dz;
            e_w     = (m_t == 1);
            e_sll   = !m_abort && m_t >= 2 && m_t <= N + 2;
            e_srl   = !m_abort && m_t == N + 3;
            e_cnt   = (!m_abort && m_t >= 3 && m_t <= N + 2) ? m_t - 3 : 0;
            e_busy  = m_abort ? (m_t == 1) : (m_t >= 1 && m_t <= N + 3);
            e_ready = m_final();
            e_dz    = m_abort && m_t >= 2;
            if (m_final() && st) m_t = 0;
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("[TB] FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic check_output();
        check_val("W_ctrl",   32'(W_ctrl),   32'(e_w));
        check_val("SLL_ctrl", 32'(SLL_ctrl), 32'(e_sll));
        check_val("SRL_ctrl", 32'(SRL_ctrl), 32'(e_srl));
        check_val("Ready",    32'(Ready),    32'(e_ready));
        check_val("Busy",     32'(Busy),     32'(e_busy));
        check_val("Div_zero", 32'(Div_zero), 32'(e_dz));
        check_val("Count",    32'(Count),    32'(e_cnt));
        check_val("strobe_overlap",
                  32'((W_ctrl & SLL_ctrl) | (W_ctrl & SRL_ctrl) | (SLL_ctrl & SRL_ctrl) |
                      (Ready & (W_ctrl | SLL_ctrl | SRL_ctrl))), 32'd0);
    endtask

    task automatic apply_stimulus(input logic rst, input logic st, input logic dz);
        Reset = rst; Start = st; Divisor_zero = dz;
        @(posedge clk);
        model_edge(rst, st, dz);
        #1;
        cyc++;
        if (W_ctrl === 1'b1) w_seen++;
        check_output();
    endtask

    // mode 0: Start low, 1: random Start only while it must be ignored, 2: Start held high.
    task automatic run_until_ready(input int limit, input int mode);
        int n = 0;
        logic st;
        do begin
            case (mode)
                1:       st = start_ignored() ? 1'($urandom) : 1'b0;
                2:       st = 1'b1;
                default: st = 1'b0;
            endcase
            apply_stimulus(1'b0, st, pick_dz());
            n++;
        end while (Ready !== 1'b1 && n < limit);
        check_val("ready_reached", 32'(Ready), 32'd1);
    endtask

    task automatic check_result(input logic [31:0] a, input logic [31:0] b);
        check_val("quotient",  dp_lo,       a / b);
        check_val("remainder", dp_hi[31:0], a % b);
    endtask

    initial begin
        int start_cyc;
        Reset = 1'b1; Start = 1'b0; Divisor_zero = 1'b0;

        // Reset wins over a simultaneous Start.
        apply_stimulus(1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] normal 100/7");
        op_a = 32'd100; op_b = 32'd7; w_seen = 0;
        apply_stimulus(1'b0, 1'b1, 1'b0);
        start_cyc = cyc;
        run_until_ready(60, 0);
        check_val("latency_normal", 32'(cyc - start_cyc), 32'(N + 4));
        check_val("quotient_100_7",  dp_lo,       32'd14);
        check_val("remainder_100_7", dp_hi[31:0], 32'd2);
        check_val("w_pulses_normal", 32'(w_seen), 32'd1);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'($urandom));

        $display("[TB] zero divisor");
        op_a = 32'd55; op_b = 32'd0;
        apply_stimulus(1'b0, 1'b1, 1'b0);
        start_cyc = cyc;
        run_until_ready(60, 0);
        check_val("latency_zero", 32'(cyc - start_cyc), 32'd2);
        check_val("div_zero_set", 32'(Div_zero), 32'd1);
        apply_stimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] busy start at Count=5, next Start clears Div_zero");
        op_a = 32'd1000; op_b = 32'd33; w_seen = 0;
        apply_stimulus(1'b0, 1'b1, 1'b0);
        start_cyc = cyc;
        for (int i = 0; i < 50 && !(SLL_ctrl === 1'b1 && Count == CW'(5)); i++)
            apply_stimulus(1'b0, 1'b0, pick_dz());
        check_val("reached_count5", 32'(Count), 32'd5);
        apply_stimulus(1'b0, 1'b1, 1'b1);
        run_until_ready(60, 0);
        check_val("latency_busy_start", 32'(cyc - start_cyc), 32'(N + 4));
        check_val("w_pulses_busy", 32'(w_seen), 32'd1);
        check_result(op_a, op_b);

        $display("[TB] mid-operation reset at Count=10");
        op_a = 32'hDEAD_BEEF; op_b = 32'd3;
        apply_stimulus(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 50 && !(SLL_ctrl === 1'b1 && Count == CW'(10)); i++)
            apply_stimulus(1'b0, 1'b0, pick_dz());
        check_val("reached_count10", 32'(Count), 32'd10);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        start_cyc = cyc;
        run_until_ready(60, 1);
        check_val("latency_after_reset", 32'(cyc - start_cyc), 32'(N + 4));
        check_result(op_a, op_b);

        $display("[TB] back-to-back with Start held high");
        op_a = 32'd12345; op_b = 32'd100;
        apply_stimulus(1'b0, 1'b1, 1'b0);
        run_until_ready(60, 2);
        check_result(op_a, op_b);
        start_cyc = cyc;
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_val("ready_one_cycle", 32'(Ready), 32'd0);
        check_val("reload_strobe",   32'(W_ctrl), 32'd1);
        run_until_ready(60, 0);
        check_val("latency_b2b", 32'(cyc - start_cyc), 32'(N + 4));
        check_result(op_a, op_b);

        $display("[TB] randomized operations");
        for (int k = 0; k < 16; k++) begin
            op_a = $urandom;
            case ($urandom_range(0, 3))
                0:       op_b = 32'd0;
                1:       op_b = $urandom_range(1, 15);
                2:       op_b = $urandom;
                default: op_b = $urandom >> $urandom_range(0, 31);
            endcase
            apply_stimulus(1'b0, 1'b1, 1'($urandom));
            start_cyc = cyc;
            run_until_ready(60, 1);
            check_val("latency_random", 32'(cyc - start_cyc), (op_b == 32'd0) ? 32'd2 : 32'(N + 4));
            if (op_b != 32'd0) check_result(op_a, op_b);
            for (int i = $urandom_range(0, 3); i > 0; i--) apply_stimulus(1'b0, 1'b0, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/div_controller.md
DIV_CONTROLLER -- requirements
Module: div_controller

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the number of divide iterations (operand width).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port Start, input, 1 bit: request a new division; sampled in IDLE and DONE only.
REQ-005 The block SHALL have port Divisor_zero, input, 1 bit: the datapath divisor register equals zero; sampled in LOAD only.
REQ-006 The block SHALL have port W_ctrl, output, 1 bit: load strobe for the dividend, remainder and divisor registers.
REQ-007 The block SHALL have port SLL_ctrl, output, 1 bit: shift-left and subtract-iterate strobe to the remainder register.
REQ-008 The block SHALL have port SRL_ctrl, output, 1 bit: final right-shift of the remainder upper half.
REQ-009 The block SHALL have port Ready, output, 1 bit: result valid, datapath frozen.
REQ-010 The block SHALL have port Busy, output, 1 bit: an operation is in progress.
REQ-011 The block SHALL have port Div_zero, output, 1 bit: the last operation aborted on a zero divisor.
REQ-012 The block SHALL have port Count, output, clog2(N)+1 bits: current iteration index.

Function
REQ-013 All outputs SHALL be registered Moore outputs decoded from state; there SHALL be no combinational path from input to output.
REQ-014 The FSM SHALL have exactly six states: IDLE, LOAD, SHIFT0, ITER, FIX, DONE.
REQ-015 In IDLE, Start=1 SHALL move the FSM to LOAD; Start=0 SHALL keep it in IDLE.
REQ-016 LOAD SHALL last one cycle with W_ctrl=1 and Count=0.
- Divisor_zero=1 in LOAD SHALL go to DONE with Div_zero set.
- Otherwise LOAD SHALL go to SHIFT0.
REQ-017 SHIFT0 SHALL last one cycle with SLL_ctrl=1 (initial remainder shift) and SHALL go to ITER.
REQ-018 ITER SHALL hold SLL_ctrl=1 for exactly N consecutive cycles.
- Count SHALL run 0..N-1, incrementing by one each cycle.
- The FSM SHALL leave ITER for FIX on the cycle after Count=N-1.
- Count SHALL NOT wrap to 0 inside ITER.
REQ-019 FIX SHALL last one cycle with SRL_ctrl=1 and SHALL go to DONE.
REQ-020 DONE SHALL hold Ready=1 and all strobes at 0 until Start=1.
- Start=1 in DONE SHALL go directly to LOAD (back-to-back operation).
- Start=1 in DONE SHALL clear Ready and Div_zero on that same transition.
REQ-021 At most one of W_ctrl, SLL_ctrl, SRL_ctrl SHALL be 1 in any cycle.
REQ-022 Ready=1 SHALL never coincide with any strobe.
REQ-023 Busy SHALL be 1 in LOAD, SHIFT0, ITER and FIX, and 0 in IDLE and DONE.
REQ-024 Start SHALL be ignored while Busy=1, with no queuing and no restart.
REQ-025 Latency SHALL be fixed: Start sampled at edge k gives Ready=1 from edge k+N+4, which is edge k+36 for N=32.
REQ-026 A zero divisor SHALL give Ready=1 and Div_zero=1 from edge k+2, with no SLL_ctrl or SRL_ctrl pulses.
REQ-027 Div_zero SHALL be 0 on every non-aborted completion.

Reset
REQ-028 Reset=1 at a rising edge SHALL force IDLE with W_ctrl, SLL_ctrl, SRL_ctrl, Ready, Busy and Div_zero all 0 and Count=0.
REQ-029 Reset SHALL apply from any state, including mid-ITER, with no further strobes after that edge.
REQ-030 When Reset and Start are both 1, Reset SHALL win and Start SHALL be discarded.
REQ-031 Reset SHALL act only at clock edges and SHALL have no asynchronous effect.

Verification
REQ-032 Reset scenario: Reset for 2 cycles, Start=0 -> IDLE; every output 0; Count=0.
REQ-033 Normal scenario, N=32, Start pulse at edge 0, Divisor_zero=0 -> required response:
- W_ctrl=1 at cycle 1 only.
- SLL_ctrl=1 for cycles 2..34 (33 cycles), with Count 0..31 during cycles 3..34.
- SRL_ctrl=1 at cycle 35 only.
- Ready=1 from cycle 36 onward; Busy=1 during cycles 1..35.
- Integrated with the datapath, 100/7 SHALL give quotient 14, remainder 2.
REQ-034 Zero-divisor scenario: Start, then Divisor_zero=1 in LOAD -> Ready=1 and Div_zero=1 at cycle 2; no SLL_ctrl or SRL_ctrl pulse; the next Start clears Div_zero.
REQ-035 Busy-Start scenario: Start re-pulsed at Count=5 in ITER -> ignored; Ready still at cycle 36; exactly one W_ctrl pulse.
REQ-036 Mid-operation reset: Reset at Count=10 -> IDLE next edge; all strobes 0; a following Start completes normally, Ready 36 cycles after that Start.
REQ-037 Back-to-back scenario: Start held high through DONE -> LOAD entered the cycle after Ready first rises; Ready=1 for exactly one cycle; the second result is Ready 36 cycles after the re-entry Start.
